// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Holds the frame FSM encoding, oversample ratio and counter sizing helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int OVERSAMPLE = 16;

    // Oversample-tick counter is wide enough for a two-stop-bit STOP phase (32 ticks).
    localparam int S_WIDTH = 5;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversample tick generator: mod-(dvsr+1) counter, s_tick while the count equals dvsr.
// Latency: clr zeroes the count on the next edge; no backpressure.
module baud_gen #(
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    output logic                  s_tick
);

    logic [DVSR_WIDTH-1:0] b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_q <= '0;
        end else if (clr || (b_q == dvsr)) begin
            b_q <= '0;
        end else begin
            b_q <= b_q + DVSR_WIDTH'(1);
        end
    end

    assign s_tick = (b_q == dvsr);

endmodule

// File: rtl/uart_tx_fifo_rd.sv
// FIFO-draining UART transmitter: pops one word in IDLE and serialises start/data/stop on tx.
// Start edge one clk after the pop; the FIFO is only popped when idle and non-empty.
module uart_tx_fifo_rd
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    input  logic                  fifo_empty,
    input  logic [DBIT-1:0]       fifo_r_data,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done_tick
);

    localparam int NW = cnt_width(DBIT);

    localparam logic [S_WIDTH-1:0] S_LAST      = S_WIDTH'(OVERSAMPLE - 1);
    localparam logic [S_WIDTH-1:0] S_STOP_LAST = S_WIDTH'(SB_TICK - 1);
    localparam logic [NW-1:0]      N_LAST      = NW'(DBIT - 1);

    uart_state_t           state_q, state_d;
    logic [S_WIDTH-1:0]    s_q, s_d;
    logic [NW-1:0]         n_q, n_d;
    logic [DBIT-1:0]       shreg_q, shreg_d;
    logic [DVSR_WIDTH-1:0] dvsr_q;
    logic                  tx_q, tx_d;
    logic                  pop;
    logic                  s_tick;
    logic                  done;

    // Pop is a pure decode so the FIFO advances in the same cycle the word is latched.
    assign pop = (state_q == IDLE) && !fifo_empty && !reset;

    baud_gen #(
        .DVSR_WIDTH(DVSR_WIDTH)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clr    (pop),
        .dvsr   (dvsr_q),
        .s_tick (s_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            if (pop) begin
                dvsr_q <= dvsr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    shreg_d = fifo_r_data;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + S_WIDTH'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + S_WIDTH'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        done    = 1'b1;
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the registered tx moves with the state register.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign fifo_rd      = pop;
    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Directed bench for uart_tx_fifo_rd: one-stop-bit and two-stop-bit instances fed from simple FIFO models.
module tb_uart_tx_fifo_rd;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr0, dvsr1;
    logic        fifo_empty0, fifo_empty1;
    logic [7:0]  r_data0, r_data1;
    logic        fifo_rd0, fifo_rd1;
    logic        tx0, tx1, busy0, busy1, done0, done1;

    logic [7:0]  mem0 [64];
    logic [7:0]  mem1 [64];
    int          wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    int          cyc = 0;
    int          n_cmp = 0, n_err = 0;
    int          last_end = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd0) rd0 <= rd0 + 1;
        if (fifo_rd1) rd1 <= rd1 + 1;
    end

    assign fifo_empty0 = (wr0 == rd0);
    assign fifo_empty1 = (wr1 == rd1);
    assign r_data0     = mem0[rd0[5:0]];
    assign r_data1     = mem1[rd1[5:0]];

    uart_tx_fifo_rd #(.DBIT(8), .SB_TICK(16), .DVSR_WIDTH(11)) u_dut0 (
        .clk          (clk),
        .reset        (reset),
        .dvsr         (dvsr0),
        .fifo_empty   (fifo_empty0),
        .fifo_r_data  (r_data0),
        .fifo_rd      (fifo_rd0),
        .tx           (tx0),
        .tx_busy      (busy0),
        .tx_done_tick (done0)
    );

    uart_tx_fifo_rd #(.DBIT(8), .SB_TICK(32), .DVSR_WIDTH(11)) u_dut1 (
        .clk          (clk),
        .reset        (reset),
        .dvsr         (dvsr1),
        .fifo_empty   (fifo_empty1),
        .fifo_r_data  (r_data1),
        .fifo_rd      (fifo_rd1),
        .tx           (tx1),
        .tx_busy      (busy1),
        .tx_done_tick (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel != 0) ? tx1 : tx0;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? done1 : done0;
    endfunction

    task automatic push0(input logic [7:0] d);
        mem0[wr0[5:0]] = d;
        wr0 = wr0 + 1;
    endtask

    // Waits for the start edge, then checks every cycle of all ten bit periods.
    // Offsets count from the first low cycle (offset 0), so the final stop cycle is total-1.
    task automatic check_frame(input int sel, input logic [7:0] data, input int d,
                               input int sb, input string tag, output int t0);
        int   per, stop_len, total, waited, len, done_cnt, done_off;
        logic b, got_b, busy_ok;
        per      = 16 * (d + 1);
        stop_len = sb * (d + 1);
        total    = 9 * per + stop_len;
        waited   = 0;
        while (tx_of(sel) !== 1'b0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        t0 = cyc;
        if (waited >= 4000) begin
            chk({tag, " start_timeout"}, 32'd0, 32'd1);
            return;
        end
        done_cnt = 0;
        done_off = -1;
        busy_ok  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b     = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : data[k-1];
            len   = (k == 9) ? stop_len : per;
            got_b = b;
            for (int j = 0; j < len; j++) begin
                if (tx_of(sel) !== b) got_b = tx_of(sel);
                if (busy_of(sel) !== 1'b1) busy_ok = 1'b0;
                if (done_of(sel) === 1'b1) begin
                    done_cnt++;
                    done_off = cyc - t0;
                end
                if (!(k == 9 && j == len - 1)) @(negedge clk);
            end
            chk($sformatf("%s bit%0d", tag, k), got_b, b);
        end
        chk({tag, " busy"}, busy_ok, 1'b1);
        chk({tag, " done_cnt"}, done_cnt, 1);
        chk({tag, " done_off"}, done_off, total - 1);
        last_end = cyc;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t0, t0b, e, p, waited;
        logic bad_tx, bad_rd, bad_busy;

        reset = 1'b1;
        dvsr0 = 11'd1;
        dvsr1 = 11'd0;
        repeat (3) @(negedge clk);
        chk("rst tx", tx0, 1'b1);
        chk("rst busy", busy0, 1'b0);
        chk("rst fifo_rd", fifo_rd0, 1'b0);
        chk("rst done", done0, 1'b0);
        reset = 1'b0;

        // Idle with empty FIFO for 100 clk.
        bad_tx = 0; bad_rd = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) bad_tx = 1;
            if (fifo_rd0 !== 1'b0) bad_rd = 1;
            if (busy0 !== 1'b0) bad_busy = 1;
        end
        chk("idle tx_low_seen", bad_tx, 1'b0);
        chk("idle rd_seen", bad_rd, 1'b0);
        chk("idle busy_seen", bad_busy, 1'b0);

        // Single frame 0xA5 at dvsr=1: 32 clk per bit, done at 320th clk of the frame.
        p = rd0;
        push0(8'hA5);
        check_frame(0, 8'hA5, 1, 16, "a5", t0);
        @(negedge clk);
        chk("a5 pops", rd0 - p, 1);

        // Back-to-back 0x00, 0xFF at dvsr=0 with a single idle clk between.
        dvsr0 = 11'd0;
        p = rd0;
        push0(8'h00);
        push0(8'hFF);
        check_frame(0, 8'h00, 0, 16, "b2b0", t0);
        e = last_end;
        check_frame(0, 8'hFF, 0, 16, "b2b1", t0b);
        chk("b2b gap", t0b - e - 1, 1);
        bad_rd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fifo_rd0 !== 1'b0) bad_rd = 1;
        end
        chk("b2b rd_after", bad_rd, 1'b0);
        chk("b2b pops", rd0 - p, 2);

        // Reset in DATA bit 3 of 0xF0 (bit 3 is low, so the line is low just before).
        dvsr0 = 11'd1;
        push0(8'hF0);
        waited = 0;
        while (tx0 !== 1'b0 && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid start_seen", waited < 4000, 1'b1);
        repeat (133) @(negedge clk);
        chk("rst_mid pre_tx", tx0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_mid tx", tx0, 1'b1);
        chk("rst_mid busy", busy0, 1'b0);
        chk("rst_mid fifo_rd", fifo_rd0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad_tx = 0; bad_rd = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) bad_tx = 1;
            if (fifo_rd0 !== 1'b0) bad_rd = 1;
        end
        chk("rst_mid post_tx", bad_tx, 1'b0);
        chk("rst_mid post_rd", bad_rd, 1'b0);

        // dvsr changed 1 -> 3 mid-frame: first frame stays at 32 clk/bit, next uses 64.
        dvsr0 = 11'd1;
        push0(8'h55);
        push0(8'h33);
        fork
            check_frame(0, 8'h55, 1, 16, "dv0", t0);
            begin
                repeat (100) @(negedge clk);
                dvsr0 = 11'd3;
            end
        join
        check_frame(0, 8'h33, 3, 16, "dv1", t0);

        // Two stop bits (SB_TICK=32) at dvsr=0: stop lasts 32 clk.
        mem1[wr1[5:0]] = 8'h3C;
        wr1 = wr1 + 1;
        check_frame(1, 8'h3C, 0, 32, "sb32", t0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
